// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous value commit,
// leading-zero blanking and whole-display blinking. Anode and segment outputs are active-low.
module fnd_scan_driver #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data,
    output logic        frame_done
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic          tick;
    logic          wrap;
    logic [15:0]   shadow_bcd;
    logic [3:0]    shadow_dp;
    logic          pending;
    logic [15:0]   disp_bcd;
    logic [3:0]    disp_dp;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          blink_off;
    logic [3:0]    lz;
    logic [3:0]    nib_p0;
    logic [7:0]    seg_p0;
    logic [3:0]    com_p0;

    assign tick      = (presc == PRESC_MAX);
    assign wrap      = tick && (idx == 2'd3);
    assign blink_off = blink_en && phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // The commit samples the shadow before a same-cycle load overwrites it,
    // so a load on the wrap tick stays pending for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            if (load)
                pending <= 1'b1;
            else if (wrap)
                pending <= 1'b0;
            if (wrap && pending) begin
                disp_bcd <= shadow_bcd;
                disp_dp  <= shadow_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage p0: select and decode the active digit from the display register.
    always_comb begin
        lz[3]  = (disp_bcd[15:12] == 4'd0);
        lz[2]  = lz[3] && (disp_bcd[11:8] == 4'd0);
        lz[1]  = lz[2] && (disp_bcd[7:4] == 4'd0);
        lz[0]  = 1'b0;
        nib_p0 = disp_bcd[{idx, 2'b00} +: 4];
        if (blank_lz && lz[idx])
            seg_p0 = 8'hFF;
        else
            seg_p0 = {~disp_dp[idx], hex7(nib_p0)};
        if (blink_off)
            com_p0 = 4'hF;
        else
            com_p0 = ~(4'b0001 << idx);
    end

    // Stage p1: registered board outputs, one cycle behind idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_com    <= 4'hF;
            fnd_data   <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            fnd_com    <= com_p0;
            fnd_data   <= seg_p0;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with DIV=4 and a two-tick blink half-period.
module tb_fnd_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    fnd_scan_driver #(.CLK_HZ(40), .SCAN_HZ(10), .BLINK_TICKS(2)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .blink_en(blink_en), .fnd_com(fnd_com),
        .fnd_data(fnd_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        blz;
        logic [7:0]  e0, e1, e2, e3;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] scan_com(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (k / 4));
    endfunction

    // Checks one 16-cycle frame starting right after a frame_done sample.
    task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input int ld_k, input logic [15:0] ld_bcd,
                             input logic [3:0] ld_dp, input string name);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("%s com k%0d", name, k), 32'(fnd_com), 32'(scan_com(k)));
            chk($sformatf("%s data k%0d", name, k), 32'(fnd_data), 32'(e[k / 4]));
            chk($sformatf("%s frame_done k%0d", name, k), 32'(frame_done), 32'(k == 15));
            if (k == ld_k) begin
                bcd_in = ld_bcd;
                dp_in  = ld_dp;
                load   = 1'b1;
            end
        end
    endtask

    task automatic wait_fd(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame_done) break;
        end
        chk(name, 32'(frame_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h0105, 4'b0000, 1'b1, 8'h92, 8'hC0, 8'hF9, 8'hFF};
        tbl[1] = '{16'h0000, 4'b0000, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
        tbl[2] = '{16'h0000, 4'b0110, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{16'h00A0, 4'b0001, 1'b1, 8'h40, 8'h88, 8'hFF, 8'hFF};
        tbl[4] = '{16'h1000, 4'b0000, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hF9};
        tbl[5] = '{16'hBCDE, 4'b1000, 1'b0, 8'h86, 8'hA1, 8'hC6, 8'h03};
        tbl[6] = '{16'h0F00, 4'b0000, 1'b1, 8'hC0, 8'hC0, 8'h8E, 8'hFF};
        tbl[7] = '{16'h0F00, 4'b0000, 1'b0, 8'hC0, 8'hC0, 8'h8E, 8'hC0};

        rst = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0; blink_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset com", 32'(fnd_com), 32'hF);
            chk("reset data", 32'(fnd_data), 32'hFF);
            chk("reset frame_done", 32'(frame_done), 32'd0);
        end
        rst = 1'b1;

        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0, "idle");
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 3, 16'h1234, 4'b0010, "hold");
        run_frame(8'h99, 8'h30, 8'hA4, 8'hF9, -1, 16'h0, 4'h0, "load1234");

        bcd_in = 16'h0001; dp_in = 4'h0; load = 1'b1;
        run_frame(8'h99, 8'h30, 8'hA4, 8'hF9, 5, 16'h0002, 4'h0, "dbl_load");
        run_frame(8'hA4, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0, "dbl_commit");

        bcd_in = 16'h0056; load = 1'b1;
        run_frame(8'hA4, 8'hC0, 8'hC0, 8'hC0, 14, 16'h0789, 4'h0, "coincide");
        run_frame(8'h82, 8'h92, 8'hC0, 8'hC0, -1, 16'h0, 4'h0, "old_shadow");
        run_frame(8'h90, 8'h80, 8'hF8, 8'hC0, -1, 16'h0, 4'h0, "new_after");

        for (int i = 0; i < 8; i++) begin
            bcd_in   = tbl[i].bcd;
            dp_in    = tbl[i].dp;
            blank_lz = tbl[i].blz;
            load     = 1'b1;
            wait_fd($sformatf("tbl%0d sync", i));
            run_frame(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3, -1, 16'h0, 4'h0,
                      $sformatf("tbl%0d", i));
        end

        blink_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                chk($sformatf("blink f%0d com k%0d", f, k), 32'(fnd_com),
                    (k >= 8) ? 32'hF : 32'(scan_com(k)));
            end
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("blink drop com k%0d", k), 32'(fnd_com),
                (k >= 8 && k <= 10) ? 32'hF : 32'(scan_com(k)));
            if (k == 10) blink_en = 1'b0;
        end
        run_frame(8'hC0, 8'hC0, 8'h8E, 8'hC0, -1, 16'h0, 4'h0, "after_blink");

        bcd_in = 16'h4321; dp_in = 4'hF; load = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            load = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("midrst com", 32'(fnd_com), 32'hF);
        chk("midrst data", 32'(fnd_data), 32'hFF);
        chk("midrst frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        chk("midrst hold com", 32'(fnd_com), 32'hF);
        rst = 1'b1;
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0, "post_rst");
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0, 4'h0, "pend_lost");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
